// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control decoder and the mult/div sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_seq_controller_if.sv
// ID-to-EX control bundle: decode request in, ALU code and mult/div sequencing out.
interface alu_seq_controller_if;

  logic       dec_valid;
  logic [1:0] alu_op;
  logic [5:0] fnctn;
  logic       flush;
  logic       stall;
  logic [3:0] alu_code;
  logic       alu_code_valid;
  logic       illegal;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       hilo_we;

  modport master (
    output dec_valid, alu_op, fnctn, flush,
    input  stall, alu_code, alu_code_valid, illegal, md_start, md_op, md_busy, hilo_we
  );

  modport slave (
    input  dec_valid, alu_op, fnctn, flush,
    output stall, alu_code, alu_code_valid, illegal, md_start, md_op, md_busy, hilo_we
  );

endinterface

// File: rtl/alu_funct_decoder.sv
// Purely combinational alu_op/funct decode into ALU code and op-class flags.
module alu_funct_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] fnctn,
  output logic [3:0] code,
  output logic       is_md,
  output logic       is_hilo,
  output logic       illegal,
  output md_op_t     md_op
);

  always_comb begin
    code    = ALU_ADD;
    is_md   = 1'b0;
    is_hilo = 1'b0;
    illegal = 1'b0;
    md_op   = md_op_t'(fnctn[1:0]);
    case (alu_op)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b10: code = ALU_OR;
      default: begin
        case (fnctn)
          F_ADD, F_ADDU:                   code = ALU_ADD;
          F_SUB, F_SUBU:                   code = ALU_SUB;
          F_AND:                           code = ALU_AND;
          F_OR:                            code = ALU_OR;
          F_XOR:                           code = ALU_XOR;
          F_NOR:                           code = ALU_NOR;
          F_SLT:                           code = ALU_SLT;
          F_SLTU:                          code = ALU_SLTU;
          F_MFHI, F_MTHI, F_MFLO, F_MTLO:  is_hilo = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU:  is_md = 1'b1;
          default:                         illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_controller.sv
// Registered ALU control decode plus an iterative MULT/DIV sequencer with HI/LO interlock.
//   state   | meaning
//   IDLE    | no mult/div in flight; HI/LO free
//   RUN     | mult/div iterating; counter counts down to the HI/LO write
module alu_seq_controller
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(max_int(MUL_CYCLES, DIV_CYCLES))
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_seq_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [3:0] dec_code;
  logic       dec_is_md;
  logic       dec_is_hilo;
  logic       dec_illegal;
  md_op_t     dec_md_op;

  alu_funct_decoder u_dec (
    .alu_op  (bus.alu_op),
    .fnctn   (bus.fnctn),
    .code    (dec_code),
    .is_md   (dec_is_md),
    .is_hilo (dec_is_hilo),
    .illegal (dec_illegal),
    .md_op   (dec_md_op)
  );

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_t           md_op_q, md_op_d;
  logic             md_start_q, md_start_d;
  logic [3:0]       alu_code_q, alu_code_d;
  logic             alu_code_valid_q, alu_code_valid_d;
  logic             illegal_q, illegal_d;

  logic md_busy;
  logic stall;
  logic accept;
  logic hilo_we;

  assign md_busy = (state_q == ST_RUN);
  assign stall   = bus.dec_valid & md_busy & (dec_is_md | dec_is_hilo);
  assign accept  = bus.dec_valid & ~stall & ~bus.flush;
  assign hilo_we = md_busy & (cnt_q == '0);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    md_op_d          = md_op_q;
    md_start_d       = 1'b0;
    alu_code_d       = alu_code_q;
    alu_code_valid_d = accept;
    illegal_d        = accept & dec_illegal;

    if (accept) begin
      alu_code_d = dec_code;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && dec_is_md) begin
          state_d    = ST_RUN;
          cnt_d      = dec_md_op[1] ? DIV_LOAD : MUL_LOAD;
          md_op_d    = dec_md_op;
          md_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Terminal count is the HI/LO write cycle; no MD op can be accepted here.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      md_op_q          <= MD_MULT;
      md_start_q       <= 1'b0;
      alu_code_q       <= 4'b0000;
      alu_code_valid_q <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      md_op_q          <= md_op_d;
      md_start_q       <= md_start_d;
      alu_code_q       <= alu_code_d;
      alu_code_valid_q <= alu_code_valid_d;
      illegal_q        <= illegal_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.alu_code       = alu_code_q;
  assign bus.alu_code_valid = alu_code_valid_q;
  assign bus.illegal        = illegal_q;
  assign bus.md_start       = md_start_q;
  assign bus.md_op          = md_op_q;
  assign bus.md_busy        = md_busy;
  assign bus.hilo_we        = hilo_we;

endmodule
